// File: rtl/addpipe_pkg.sv
// Shared types and constants for the adder-pipeline controller.
package addpipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } addpipe_state_t;

    localparam int OPCNT_W        = 16;
    localparam int STAGES_DEFAULT = 4;

endpackage

// File: rtl/addpipe_vchain.sv
// Valid-bit shift chain for the adder pipeline plus per-stage load enables.
// The whole chain moves together (global stall); a bubble is never collapsed.
module addpipe_vchain
    import addpipe_pkg::*;
#(
    parameter int STAGES = STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              flush_i,
    input  logic              advance_i,
    input  logic              accept_i,
    output logic [STAGES-1:0] v_o,
    output logic [STAGES-1:0] v_next_o,
    output logic [STAGES-1:0] load_o
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;

    // Next valid vector: emptied by flush, shifted on advance, otherwise held.
    always_comb begin
        v_d = v_q;
        if (flush_i) begin
            v_d = '0;
        end else if (advance_i) begin
            v_d = {v_q[STAGES-2:0], accept_i};
        end
    end

    // Valid-vector register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // Stage i loads when the chain advances and stage i-1 holds a valid operand.
    always_comb begin
        load_o = '0;
        if (!clr_i && !flush_i) begin
            load_o[0] = accept_i;
            for (int i = 1; i < STAGES; i++) begin
                load_o[i] = advance_i & v_q[i-1];
            end
        end
    end

    assign v_o      = v_q;
    assign v_next_o = v_d;

endmodule

// File: rtl/addpipe_ctrl.sv
// Sequencing controller for a STAGES-deep adder pipeline: handshake, drain,
// flush and per-stage load/clear generation.
// Optional feature: define ADDPIPE_CTRL_STATS_EN to build the completed-operation
// counter; when undefined op_count is tied to zero and no counter flops exist.
module addpipe_ctrl
    import addpipe_pkg::*;
#(
    parameter int STAGES = STAGES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    input  logic                         drain,
    output logic                         drain_done,
    output logic [STAGES-1:0]            stage_load,
    output logic [STAGES-1:0]            stage_clr,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [OPCNT_W-1:0]           op_count
);

    localparam int OCC_W = $clog2(STAGES + 1);

    addpipe_state_t    state_q;
    addpipe_state_t    state_d;
    logic              advance;
    logic              accept;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_next;

    assign accept = in_valid & in_ready;

    addpipe_vchain #(
        .STAGES (STAGES)
    ) u_vchain (
        .clk       (clk),
        .clr_i     (clr),
        .flush_i   (flush),
        .advance_i (advance),
        .accept_i  (accept),
        .v_o       (v_q),
        .v_next_o  (v_next),
        .load_o    (stage_load)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (drain) begin
                    state_d = ST_DRAIN;
                end else if (accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (drain) begin
                    state_d = ST_DRAIN;
                end else if (v_next == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (v_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_FLUSH;
        end
    end

    // Handshake and stage-control outputs; clr and flush mask everything.
    always_comb begin
        advance    = (state_q != ST_FLUSH) && (!v_q[STAGES-1] || out_ready);
        in_ready   = advance && ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !flush && !clr;
        out_valid  = v_q[STAGES-1] && (state_q != ST_FLUSH) && !flush && !clr;
        drain_done = (state_q == ST_DRAIN) && (v_q == '0) && !flush && !clr;
        stage_clr  = (clr || flush) ? {STAGES{1'b1}} : {STAGES{1'b0}};
    end

    // Population count of the registered valid vector.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(v_q[i]);
        end
    end

`ifdef ADDPIPE_CTRL_STATS_EN
    logic [OPCNT_W-1:0] op_count_q;

    // Completed-operation counter, wraps naturally at 2^OPCNT_W.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_count_q <= '0;
        end else if (out_valid && out_ready) begin
            op_count_q <= op_count_q + 1'b1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: doc/addpipe_ctrl.md
ADDPIPE_CTRL -- requirements
Module: addpipe_ctrl

Interface
REQ-001 STAGES, default 4, number of adder pipeline register stages sequenced (legal 2..16).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 clr  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  upstream operand pair valid.
REQ-005 in_ready  output  1  controller accepts operands this cycle.
REQ-006 out_valid  output  1  final stage holds a valid sum.
REQ-007 out_ready  input  1  downstream takes the sum this cycle.
REQ-008 flush  input  1  discard all in-flight operations.
REQ-009 drain  input  1  stop accepting, empty the pipeline.
REQ-010 drain_done  output  1  one-cycle pulse when drain completes.
REQ-011 stage_load  output  STAGES  per-stage register load enable, bit i drives stage i.
REQ-012 stage_clr  output  STAGES  per-stage register synchronous clear, bit i drives stage i.
REQ-013 occupancy  output  $clog2(STAGES+1)  count of valid stages.
REQ-014 op_count  output  16  completed-operation count.

Function
REQ-015 Internal valid vector v[STAGES-1:0]; out_valid SHALL equal v[STAGES-1] except forced 0 in FLUSH or while flush=1.
REQ-016 advance SHALL be (!v[STAGES-1] | out_ready) in IDLE, RUN, DRAIN; 0 in FLUSH.
REQ-017 in_ready SHALL be advance in IDLE/RUN, 0 in DRAIN/FLUSH or while flush=1; accept = in_valid & in_ready.
REQ-018 stage_load[0] SHALL equal accept; stage_load[i] SHALL equal advance & v[i-1] for i>=1; global stall, no bubble collapsing.
REQ-019 On advance: v[0] <= accept, v[i] <= v[i-1]; no advance: v held.
REQ-020 Latency: operand accepted in cycle t SHALL present out_valid in cycle t+STAGES absent stalls.
REQ-021 occupancy SHALL equal popcount(v), combinational from registered v.
REQ-022 States IDLE, RUN, DRAIN, FLUSH; IDLE->RUN on accept; RUN->IDLE when next v is all-zero.
REQ-023 drain=1 in IDLE or RUN SHALL enter DRAIN next cycle; drain ignored in DRAIN/FLUSH.
REQ-024 DRAIN: pipeline advances per REQ-016; in the DRAIN cycle with occupancy==0, drain_done=1 and next state IDLE; drain from empty pulses drain_done one cycle after drain.
REQ-025 flush=1 in any state: stage_clr all ones and stage_load all zero that cycle, v<=0, next state FLUSH; flush has priority over drain, accept and output handshake.
REQ-026 FLUSH lasts exactly one cycle (in_ready=0, out_valid=0), then IDLE; a pending drain is aborted with no drain_done.
REQ-027 Outside reset and flush, stage_clr SHALL be all zero.
REQ-028 op_count SHALL increment on out_valid & out_ready, wrapping 0xFFFF->0x0000.

Reset
REQ-029 clr=1 SHALL set state IDLE, v=0, op_count=0 at the edge.
REQ-030 While clr=1: stage_clr all ones, stage_load 0, in_ready 0, out_valid 0, drain_done 0; clr overrides flush and drain.
REQ-031 Reset mid-operation SHALL discard all in-flight operations with no drain_done.

Configuration
REQ-032 Macro ADDPIPE_CTRL_STATS_EN defined: op_count per REQ-028.
REQ-033 Macro undefined: op_count tied to 0, no counter flops; all other behaviour identical.

Structure
REQ-034 Package addpipe_pkg SHALL hold state typedef addpipe_state_t, OPCNT_W=16 and STAGES_DEFAULT=4.
REQ-035 Valid-bit shift chain with load generation SHALL be sub-module addpipe_vchain; FSM, handshake and counter stay in addpipe_ctrl.

Verification
REQ-036 STAGES=4, out_ready=1, in_valid=1 for 3 cycles from t=0 -> out_valid at t=4,5,6, occupancy peaks at 3, op_count=3.
REQ-037 Pipeline full, out_ready=0 for 5 cycles -> in_ready=0, stage_load=0, v and occupancy=4 held; out_ready=1 resumes one output per cycle.
REQ-038 Occupancy 2, drain=1 -> in_ready=0 next cycle, drain_done single pulse the cycle occupancy reads 0, state IDLE after.
REQ-039 Occupancy 3, flush=1 with drain pending -> stage_clr=4'b1111 one cycle, occupancy 0, no drain_done, in_ready=1 two cycles later.
REQ-040 op_count preloaded to 0xFFFF via 65535 transfers, one more transfer -> 0x0000; with macro undefined op_count stays 0.
REQ-041 clr=1 mid-stream with flush=1 -> stage_clr all ones, all outputs at reset values, first accept after clr emerges after exactly STAGES cycles.
